cpu_prog_loader: RTL

//  Writer side of the program ROM/RAM read by the PC-driven fetch path. Receives a framed byte

---
 rtl/cpu_prog_loader_if.sv | 30 +++
 rtl/cpu_prog_loader.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_prog_loader_if.sv
// Byte-stream input and program-memory write bundle for cpu_prog_loader.
// The master side feeds bytes and LOAD_REQ; the slave side (the loader)
// drives the memory write port and the CPU hold/status flags.
interface cpu_prog_loader_if #(
  parameter int WIDTH  = 13,
  parameter int IWIDTH = 5
);
  localparam int AW = WIDTH - IWIDTH;

  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic             load_req;
  logic [AW-1:0]    pm_addr;
  logic [WIDTH-1:0] pm_data;
  logic             pm_we;
  logic             cpu_hold;
  logic             done;
  logic             err;

  modport master (
    output in_data, in_valid, load_req,
    input  in_ready, pm_addr, pm_data, pm_we, cpu_hold, done, err
  );

  modport slave (
    input  in_data, in_valid, load_req,
    output in_ready, pm_addr, pm_data, pm_we, cpu_hold, done, err
  );
endinterface

// File: rtl/cpu_prog_loader.sv
// Program loader: receives a framed byte stream (SYNC, LEN, N x {HI,LO}, CHK),
// writes the assembled instruction words to program memory at sequential
// addresses and keeps the CPU held in reset until a frame checks out.
module cpu_prog_loader #(
  parameter int         WIDTH     = 13,
  parameter int         IWIDTH    = 5,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  localparam int        AW        = WIDTH - IWIDTH
) (
  input  logic            clk,
  input  logic            rst,
  cpu_prog_loader_if.slave bus
);

  typedef enum logic [2:0] {
    ST_SYNC  = 3'd0,
    ST_LEN   = 3'd1,
    ST_HI    = 3'd2,
    ST_LO    = 3'd3,
    ST_WRITE = 3'd4,
    ST_CHK   = 3'd5,
    ST_RUN   = 3'd6
  } state_e;

  // Any bit of HI above the instruction word is illegal.
  function automatic logic hi_upper_bad(input logic [7:0] hi);
    return |(hi >> (WIDTH - 8));
  endfunction

  // Instruction word = low bits of HI concatenated with LO.
  function automatic logic [WIDTH-1:0] make_word(input logic [7:0] hi, input logic [7:0] lo);
    return {hi[WIDTH-9:0], lo};
  endfunction

  // Running frame checksum: plain XOR over LEN and all payload bytes.
  function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       hi_q, hi_d;
  logic [7:0]       chk_q, chk_d;
  logic             word_err_q, word_err_d;
  logic             err_q, err_d;
  logic [AW-1:0]    pm_addr_q, pm_addr_d;
  logic [WIDTH-1:0] pm_data_q, pm_data_d;
  logic             pm_we_q, pm_we_d;
  logic             in_ready_q, in_ready_d;
  logic             cpu_hold_q, cpu_hold_d;
  logic             done_q, done_d;
  logic             accept_s;

  assign accept_s = bus.in_valid && in_ready_q;

  // Next-state and datapath decode; outputs are decoded from the next state
  // so every status flag is registered and aligned with the state it reflects.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    chk_d      = chk_q;
    word_err_d = word_err_q;
    err_d      = err_q;
    pm_addr_d  = pm_addr_q;
    pm_data_d  = pm_data_q;

    case (state_q)
      ST_SYNC: begin
        if (accept_s && (bus.in_data == SYNC_BYTE)) begin
          state_d = ST_LEN;
          err_d   = 1'b0;
        end else begin
          state_d = ST_SYNC;
        end
      end
      ST_LEN: begin
        if (accept_s) begin
          cnt_d      = bus.in_data;
          chk_d      = bus.in_data;
          pm_addr_d  = {AW{1'b0}};
          word_err_d = 1'b0;
          if (bus.in_data == 8'd0) begin
            state_d = ST_CHK;
          end else begin
            state_d = ST_HI;
          end
        end else begin
          state_d = ST_LEN;
        end
      end
      ST_HI: begin
        if (accept_s) begin
          hi_d  = bus.in_data;
          chk_d = chk_fold(chk_q, bus.in_data);
          if (hi_upper_bad(bus.in_data)) begin
            word_err_d = 1'b1;
          end else begin
            word_err_d = word_err_q;
          end
          state_d = ST_LO;
        end else begin
          state_d = ST_HI;
        end
      end
      ST_LO: begin
        if (accept_s) begin
          chk_d     = chk_fold(chk_q, bus.in_data);
          pm_data_d = make_word(hi_q, bus.in_data);
          state_d   = ST_WRITE;
        end else begin
          state_d = ST_LO;
        end
      end
      ST_WRITE: begin
        // The write itself happens this cycle; the address advances afterwards.
        pm_addr_d = pm_addr_q + {{(AW-1){1'b0}}, 1'b1};
        cnt_d     = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = ST_CHK;
        end else begin
          state_d = ST_HI;
        end
      end
      ST_CHK: begin
        if (accept_s) begin
          if ((bus.in_data == chk_q) && !word_err_q) begin
            state_d = ST_RUN;
          end else begin
            err_d   = 1'b1;
            state_d = ST_SYNC;
          end
        end else begin
          state_d = ST_CHK;
        end
      end
      ST_RUN: begin
        if (bus.load_req) begin
          state_d = ST_SYNC;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_SYNC;
      end
    endcase

    in_ready_d = (state_d == ST_SYNC) || (state_d == ST_LEN) || (state_d == ST_HI) ||
                 (state_d == ST_LO)   || (state_d == ST_CHK);
    pm_we_d    = (state_d == ST_WRITE);
    cpu_hold_d = (state_d != ST_RUN);
    done_d     = (state_d == ST_RUN);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_SYNC;
      cnt_q      <= 8'd0;
      hi_q       <= 8'd0;
      chk_q      <= 8'd0;
      word_err_q <= 1'b0;
      err_q      <= 1'b0;
      pm_addr_q  <= {AW{1'b0}};
      pm_data_q  <= {WIDTH{1'b0}};
      pm_we_q    <= 1'b0;
      in_ready_q <= 1'b1;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      chk_q      <= chk_d;
      word_err_q <= word_err_d;
      err_q      <= err_d;
      pm_addr_q  <= pm_addr_d;
      pm_data_q  <= pm_data_d;
      pm_we_q    <= pm_we_d;
      in_ready_q <= in_ready_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.pm_addr  = pm_addr_q;
  assign bus.pm_data  = pm_data_q;
  // A reset arriving in the WRITE cycle must cancel the in-flight write,
  // so the registered strobe is masked by rst.
  assign bus.pm_we    = pm_we_q && !rst;
  assign bus.cpu_hold = cpu_hold_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule
